gradient_stream_3x3: RTL and testbench

//   Streaming central-difference gradient engine for raster-order pixel frames of IMG_W x IMG_H.
//   Two line buffers plus a 3x3 window produce signed Gx/Gy for every pixel, with border pixels flagged.
//   A drain state lets the last row finish without extra input.

---
 rtl/gradient_stream_3x3.sv | 216 +++++++++++++++++++++
 tb/tb_gradient_stream_3x3.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/gradient_stream_3x3.sv
// Streaming 3x3 central-difference gradient engine (Gx/Gy) with border flags and end-of-frame drain.
// Optional GRAD_MAG_EN adds the registered grad_mag = |gx|+|gy| output.
module gradient_stream_3x3 #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 64,
    parameter int unsigned IMG_H  = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   pix_in,
    input  logic                pix_valid,
    output logic                pix_ready,
    output logic [DATA_W:0]     gx_out,
    output logic [DATA_W:0]     gy_out,
    output logic                grad_valid,
    output logic                grad_border,
    output logic                grad_sof,
`ifdef GRAD_MAG_EN
    output logic                grad_eol,
    output logic [DATA_W+1:0]   grad_mag
`else
    output logic                grad_eol
`endif
);

    localparam int unsigned GW = DATA_W + 1;
    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam int unsigned NW = $clog2(IMG_W * IMG_H);
    localparam int unsigned FW = $clog2(IMG_W + 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [NW-1:0]       in_cnt;
    logic [FW-1:0]       flush_cnt;
    logic [CW-1:0]       wr_col;
    logic [CW-1:0]       out_col;
    logic [RW-1:0]       out_row;

    logic [DATA_W-1:0]   lb0 [IMG_W];
    logic [DATA_W-1:0]   lb1 [IMG_W];

    logic [DATA_W-1:0]   bot_d1;
    logic [DATA_W-1:0]   mid_d1;
    logic [DATA_W-1:0]   mid_d2;
    logic [DATA_W-1:0]   top_d1;

    logic                push_c;
    logic                emit_c;
    logic [DATA_W-1:0]   push_pix_c;
    logic [DATA_W-1:0]   tap1_c;
    logic [DATA_W-1:0]   tap2_c;
    logic [GW-1:0]       gx_c;
    logic [GW-1:0]       gy_c;
    logic                border_c;
    logic                in_last_fill_c;
    logic                in_last_frame_c;
    logic                flush_last_c;

    assign in_last_fill_c  = (in_cnt == NW'(IMG_W));
    assign in_last_frame_c = (in_cnt == NW'(IMG_W * IMG_H - 1));
    assign flush_last_c    = (flush_cnt == FW'(IMG_W));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (pix_valid && in_last_fill_c)  state_nxt = RUN;
            RUN:     if (pix_valid && in_last_frame_c) state_nxt = FLUSH;
            FLUSH:   if (flush_last_c)                 state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // Per-state push/emit decode; FLUSH pushes zeros without consuming input
    always_comb begin
        push_c     = 1'b0;
        emit_c     = 1'b0;
        push_pix_c = '0;
        case (state)
            FILL: begin
                push_c     = pix_valid;
                push_pix_c = pix_in;
            end
            RUN: begin
                push_c     = pix_valid;
                emit_c     = pix_valid;
                push_pix_c = pix_in;
            end
            FLUSH: begin
                push_c = 1'b1;
                emit_c = 1'b1;
            end
            default: begin
                push_c = 1'b0;
            end
        endcase
    end

    // Counters and ready flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt    <= '0;
            flush_cnt <= '0;
            wr_col    <= '0;
            out_col   <= '0;
            out_row   <= '0;
            pix_ready <= 1'b1;
        end else begin
            pix_ready <= (state_nxt != FLUSH);
            if (state == FLUSH) begin
                in_cnt    <= '0;
                flush_cnt <= flush_last_c ? '0 : flush_cnt + FW'(1);
            end else begin
                flush_cnt <= '0;
                if (pix_valid) begin
                    in_cnt <= in_cnt + NW'(1);
                end
            end
            if (push_c) begin
                wr_col <= (wr_col == CW'(IMG_W - 1)) ? '0 : wr_col + CW'(1);
            end
            if (emit_c) begin
                if (out_col == CW'(IMG_W - 1)) begin
                    out_col <= '0;
                    out_row <= (out_row == RW'(IMG_H - 1)) ? '0 : out_row + RW'(1);
                end else begin
                    out_col <= out_col + CW'(1);
                end
            end
        end
    end

    // Line buffers: lb0 delays by one line, lb1 by two; contents need no reset
    assign tap1_c = lb0[wr_col];
    assign tap2_c = lb1[wr_col];

    always_ff @(posedge clk) begin
        if (push_c) begin
            lb0[wr_col] <= push_pix_c;
            lb1[wr_col] <= tap1_c;
        end
    end

    // Window taps around the centre pixel (push index - IMG_W - 1)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bot_d1 <= '0;
            mid_d1 <= '0;
            mid_d2 <= '0;
            top_d1 <= '0;
        end else if (push_c) begin
            bot_d1 <= push_pix_c;
            mid_d1 <= tap1_c;
            mid_d2 <= mid_d1;
            top_d1 <= tap2_c;
        end
    end

    assign gx_c     = GW'(tap1_c) - GW'(mid_d2);
    assign gy_c     = GW'(bot_d1) - GW'(top_d1);
    assign border_c = (out_row == '0) || (out_row == RW'(IMG_H - 1)) ||
                      (out_col == '0) || (out_col == CW'(IMG_W - 1));

`ifdef GRAD_MAG_EN
    logic [GW-1:0]     abs_gx_c;
    logic [GW-1:0]     abs_gy_c;
    logic [DATA_W+1:0] mag_c;

    assign abs_gx_c = gx_c[GW-1] ? (GW'(0) - gx_c) : gx_c;
    assign abs_gy_c = gy_c[GW-1] ? (GW'(0) - gy_c) : gy_c;
    assign mag_c    = (DATA_W+2)'(abs_gx_c) + (DATA_W+2)'(abs_gy_c);
`endif

    // Output register: results and flags only alongside grad_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gx_out      <= '0;
            gy_out      <= '0;
            grad_valid  <= 1'b0;
            grad_border <= 1'b0;
            grad_sof    <= 1'b0;
            grad_eol    <= 1'b0;
`ifdef GRAD_MAG_EN
            grad_mag    <= '0;
`endif
        end else begin
            grad_valid  <= emit_c;
            grad_border <= emit_c && border_c;
            grad_sof    <= emit_c && (out_row == '0) && (out_col == '0);
            grad_eol    <= emit_c && (out_col == CW'(IMG_W - 1));
            gx_out      <= (emit_c && !border_c) ? gx_c : '0;
            gy_out      <= (emit_c && !border_c) ? gy_c : '0;
`ifdef GRAD_MAG_EN
            grad_mag    <= (emit_c && !border_c) ? mag_c : '0;
`endif
        end
    end

endmodule

// File: tb/tb_gradient_stream_3x3.sv
// Scoreboard bench for gradient_stream_3x3 on a 4x4 frame of 8-bit pixels.
module tb_gradient_stream_3x3;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned IMG_W  = 4;
    localparam int unsigned IMG_H  = 4;

    logic              clk;
    logic              rst_n;
    logic [7:0]        pix_in;
    logic              pix_valid;
    logic              pix_ready;
    logic [8:0]        gx_out;
    logic [8:0]        gy_out;
    logic              grad_valid;
    logic              grad_border;
    logic              grad_sof;
    logic              grad_eol;
`ifdef GRAD_MAG_EN
    logic [9:0]        grad_mag;
`endif

    typedef struct {
        logic [8:0] gx;
        logic [8:0] gy;
        logic       border;
        logic       sof;
        logic       eol;
        logic [9:0] mag;
    } exp_t;

    exp_t q[$];
    int   img [4][4];
    int   checks = 0;
    int   errors = 0;

    gradient_stream_3x3 #(
        .DATA_W(DATA_W),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .gx_out     (gx_out),
        .gy_out     (gy_out),
        .grad_valid (grad_valid),
        .grad_border(grad_border),
        .grad_sof   (grad_sof),
`ifdef GRAD_MAG_EN
        .grad_eol   (grad_eol),
        .grad_mag   (grad_mag)
`else
        .grad_eol   (grad_eol)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected responses straight from the gradient definition on the frame array
    task automatic load_expect();
        exp_t e;
        int   dx;
        int   dy;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                e.border = (r == 0) || (r == 3) || (c == 0) || (c == 3);
                e.sof    = (r == 0) && (c == 0);
                e.eol    = (c == 3);
                dx = e.border ? 0 : img[r][c+1] - img[r][c-1];
                dy = e.border ? 0 : img[r+1][c] - img[r-1][c];
                e.gx  = 9'(dx);
                e.gy  = 9'(dy);
                e.mag = 10'((dx < 0 ? -dx : dx) + (dy < 0 ? -dy : dy));
                q.push_back(e);
            end
        end
    endtask

    task automatic send_pixel(input int v);
        int t = 0;
        pix_valid = 1'b1;
        pix_in    = 8'(v);
        while (!pix_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait_bound", 32'(t < 50), 32'd1);
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic send_frame(input int gap_max, input bit check_hs);
        int n;
        int v;
        load_expect();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                send_pixel(img[r][c]);
                if (gap_max > 0 && !(r == 3 && c == 3)) begin
                    repeat ($urandom_range(0, gap_max)) @(negedge clk);
                end
            end
        end
        if (check_hs) begin
            n = 0;
            v = 0;
            while (!pix_ready && n < 20) begin
                if (grad_valid) v++;
                @(negedge clk);
                n++;
            end
            chk("flush_ready_low_cycles", 32'(n), 32'd5);
            chk("flush_valid_strobes", 32'(v), 32'd5);
        end
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk(name, 32'(q.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    // Monitor: pop and compare on each output strobe; idle outputs must be zero
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("reset_ready", 32'(pix_ready), 32'd1);
                chk("reset_outputs", {18'd0, gx_out, gy_out, grad_valid, grad_border, grad_sof, grad_eol}, 32'd0);
            end else if (grad_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("gx", 32'(gx_out), 32'(e.gx));
                    chk("gy", 32'(gy_out), 32'(e.gy));
                    chk("border", 32'(grad_border), 32'(e.border));
                    chk("sof", 32'(grad_sof), 32'(e.sof));
                    chk("eol", 32'(grad_eol), 32'(e.eol));
`ifdef GRAD_MAG_EN
                    chk("mag", 32'(grad_mag), 32'(e.mag));
`endif
                end
            end else begin
                chk("idle_flags_zero", {29'd0, grad_border, grad_sof, grad_eol}, 32'd0);
            end
        end
    end

    initial begin
        pix_valid = 1'b0;
        pix_in    = '0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", 32'(pix_ready), 32'd1);

        // Horizontal ramp: interior gx=20, gy=0
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) img[r][c] = 10 * c;
        send_frame(0, 1'b0);
        wait_drain("drain_ramp");

        // Planar 16*row+col: interior gx=2, gy=32
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) img[r][c] = 16 * r + c;
        send_frame(0, 1'b0);
        wait_drain("drain_plane");

        // Descending plane: gx=9'h1FE, gy=9'h1E0, mag=34
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) img[r][c] = 255 - 16 * r - c;
        send_frame(0, 1'b0);
        wait_drain("drain_negative");

        // Extreme swings plus random gaps and flush handshake timing
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) img[r][c] = ((r + c) % 2 == 0) ? 255 : 0;
        img[1][1] = 7;
        img[2][2] = 200;
        send_frame(3, 1'b1);
        wait_drain("drain_gaps");

        // Back-to-back frames, second constant
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) img[r][c] = 10 * c;
        send_frame(0, 1'b0);
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) img[r][c] = 100;
        send_frame(0, 1'b0);
        wait_drain("drain_back_to_back");

        // Reset after pixel 7 aborts the frame; next ramp frame is clean
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) img[r][c] = 255 - 16 * r - c;
        load_expect();
        for (int i = 0; i < 7; i++) send_pixel(img[i / 4][i % 4]);
        @(negedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) img[r][c] = 10 * c;
        send_frame(0, 1'b0);
        wait_drain("drain_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
